// File: rtl/serial_add3_ctrl.sv
// Sequential three-operand adder: in1+in2+in3+cin, two bits per cycle,
// with valid/ready handshakes on both sides and a synchronous flush.
module serial_add3_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             cin,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] sum,
  output logic             busy
);

  localparam int NSL   = WIDTH / 2;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSL - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [1:0]       cr_q, cr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH+1:0] sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       t;

  // Slice total a+b+c+cr: at most 3+3+3+2 = 11, so the carry out is 0..2.
  always_comb begin
    t = {2'b00, a_q[1:0]} + {2'b00, b_q[1:0]} + {2'b00, c_q[1:0]} + {2'b00, cr_q};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    cr_d        = cr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cr_d        = '0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d     = in1;
            b_d     = in2;
            c_d     = in3;
            cr_d    = {1'b0, cin};
            cnt_d   = '0;
            sum_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          sum_d[{cnt_q, 1'b0} +: 2] = t[1:0];
          cr_d  = t[3:2];
          a_d   = a_q >> 2;
          b_d   = b_q >> 2;
          c_d   = c_q >> 2;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          // First DONE cycle deposits the final carry; the result is then
          // presented until the consumer takes it.
          if (!out_valid_q) begin
            sum_d[WIDTH+1:WIDTH] = cr_q;
            out_valid_d          = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cr_q        <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      cr_q        <= cr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_serial_add3_ctrl.sv
// Bench for serial_add3_ctrl: directed WIDTH=8 cases plus randomized
// regressions at WIDTH=2 and WIDTH=16 against an arithmetic reference.
module tb_serial_add3_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: WIDTH=2, 1: WIDTH=8, 2: WIDTH=16
  int          wd [3] = '{2, 8, 16};
  logic        in_valid_v  [3];
  logic        cin_v       [3];
  logic        flush_v     [3];
  logic        out_ready_v [3];
  logic [15:0] in1_v [3];
  logic [15:0] in2_v [3];
  logic [15:0] in3_v [3];
  logic        in_ready_v  [3];
  logic        out_valid_v [3];
  logic        busy_v      [3];
  logic [17:0] sum_v       [3];

  logic        ir2, ir8, ir16, ov2, ov8, ov16, bz2, bz8, bz16;
  logic [3:0]  s2;
  logic [9:0]  s8;
  logic [17:0] s16;

  serial_add3_ctrl #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir2),
    .in1(in1_v[0][1:0]), .in2(in2_v[0][1:0]), .in3(in3_v[0][1:0]), .cin(cin_v[0]),
    .flush(flush_v[0]), .out_valid(ov2), .out_ready(out_ready_v[0]), .sum(s2), .busy(bz2)
  );
  serial_add3_ctrl #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir8),
    .in1(in1_v[1][7:0]), .in2(in2_v[1][7:0]), .in3(in3_v[1][7:0]), .cin(cin_v[1]),
    .flush(flush_v[1]), .out_valid(ov8), .out_ready(out_ready_v[1]), .sum(s8), .busy(bz8)
  );
  serial_add3_ctrl #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir16),
    .in1(in1_v[2]), .in2(in2_v[2]), .in3(in3_v[2]), .cin(cin_v[2]),
    .flush(flush_v[2]), .out_valid(ov16), .out_ready(out_ready_v[2]), .sum(s16), .busy(bz16)
  );

  assign in_ready_v[0] = ir2;  assign in_ready_v[1] = ir8;  assign in_ready_v[2] = ir16;
  assign out_valid_v[0] = ov2; assign out_valid_v[1] = ov8; assign out_valid_v[2] = ov16;
  assign busy_v[0] = bz2;      assign busy_v[1] = bz8;      assign busy_v[2] = bz16;
  assign sum_v[0] = {14'd0, s2};
  assign sum_v[1] = {8'd0, s8};
  assign sum_v[2] = s16;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accept edge; operands are then scrambled.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic ci, input string tag);
    int n;
    n = 0;
    while (!in_ready_v[k] && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, in_ready_v[k], 1);
    in_valid_v[k] = 1'b1;
    in1_v[k] = a; in2_v[k] = b; in3_v[k] = c; cin_v[k] = ci;
    tick();
    in_valid_v[k] = 1'b0;
    in1_v[k] = 16'($urandom); in2_v[k] = 16'($urandom);
    in3_v[k] = 16'($urandom); cin_v[k] = 1'($urandom);
  endtask

  task automatic wait_valid(input int k, input string tag);
    int n;
    n = 0;
    while (!out_valid_v[k] && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid_v[k], 1);
  endtask

  task automatic recv(input int k, input logic [17:0] exp, input string tag);
    wait_valid(k, tag);
    check({tag, "_sum"}, sum_v[k], exp);
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    check({tag, "_released"}, out_valid_v[k], 0);
  endtask

  // Exact cycle-by-cycle latency and handshake check on the WIDTH=8 unit.
  task automatic lat_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input logic ci, input logic [17:0] exp, input string tag);
    int lat;
    lat = wd[1] / 2 + 1;
    send(1, a, b, c, ci, tag);
    check({tag, "_rdy_low"}, in_ready_v[1], 0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      check({tag, "_ov_timing"}, out_valid_v[1], (i == lat));
      check({tag, "_rdy_low"}, in_ready_v[1], 0);
      check({tag, "_busy"}, busy_v[1], 1);
    end
    check({tag, "_sum"}, sum_v[1], exp);
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;
    check({tag, "_ov_clear"}, out_valid_v[1], 0);
    check({tag, "_rdy_back"}, in_ready_v[1], 1);
  endtask

  task automatic run_random(input int k, input int n);
    logic [15:0] m;
    m = 16'((32'd1 << wd[k]) - 1);
    exp_q.delete();
    fork
      begin
        logic [15:0] a, b, c;
        logic        ci, rdy, acc;
        int          gap, cnt;
        for (int i = 0; i < n; i++) begin
          gap = $urandom_range(0, 3);
          repeat (gap) tick();
          a = 16'($urandom) & m; b = 16'($urandom) & m; c = 16'($urandom) & m;
          ci = 1'($urandom);
          in_valid_v[k] = 1'b1;
          in1_v[k] = a; in2_v[k] = b; in3_v[k] = c; cin_v[k] = ci;
          acc = 1'b0;
          cnt = 0;
          while (!acc && cnt < 500) begin
            rdy = in_ready_v[k];
            tick();
            cnt++;
            if (rdy) acc = 1'b1;
          end
          in_valid_v[k] = 1'b0;
          if (acc) exp_q.push_back(32'(a) + 32'(b) + 32'(c) + 32'(ci));
          else check("rand_accept_timeout", in_ready_v[k], 1);
        end
      end
      begin
        int got, cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < n * 60) begin
          out_ready_v[k] = ($urandom_range(0, 1) == 1);
          if (out_valid_v[k] && out_ready_v[k]) begin
            if (exp_q.size() == 0) check("rand_spurious_valid", out_valid_v[k], 0);
            else check("rand_sum", sum_v[k], exp_q.pop_front());
            got++;
          end
          tick();
          cyc++;
        end
        out_ready_v[k] = 1'b0;
        check("rand_count", got, n);
      end
    join
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k] = 1'b0; cin_v[k] = 1'b0; flush_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      in1_v[k] = '0; in2_v[k] = '0; in3_v[k] = '0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready", in_ready_v[k], 1);
      check("rst_out_valid", out_valid_v[k], 0);
      check("rst_busy", busy_v[k], 0);
      check("rst_sum", sum_v[k], 0);
    end
    rst_n = 1'b1;
    tick();

    lat_op(16'h00, 16'h00, 16'h00, 1'b0, 18'h000, "zero");
    lat_op(16'hFF, 16'hFF, 16'hFF, 1'b1, 18'h2FE, "max");
    lat_op(16'h55, 16'hAA, 16'h01, 1'b0, 18'h100, "ripple");

    // Backpressure: result held, new operands ignored until released.
    send(1, 16'hFF, 16'hFF, 16'hFF, 1'b1, "bp");
    wait_valid(1, "bp");
    in_valid_v[1] = 1'b1;
    in1_v[1] = 16'h11; in2_v[1] = 16'h22; in3_v[1] = 16'h33; cin_v[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", out_valid_v[1], 1);
      check("bp_hold_sum", sum_v[1], 18'h2FE);
      check("bp_in_ready", in_ready_v[1], 0);
      tick();
    end
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;
    check("bp_idle_ready", in_ready_v[1], 1);
    check("bp_idle_ov", out_valid_v[1], 0);
    tick();
    in_valid_v[1] = 1'b0;
    check("bp_accept_busy", busy_v[1], 1);
    recv(1, 18'h066, "bp_next");

    // Flush on the second RUN cycle.
    send(1, 16'hFF, 16'hFF, 16'hFF, 1'b1, "fl");
    tick();
    flush_v[1] = 1'b1;
    tick();
    flush_v[1] = 1'b0;
    check("fl_idle_ready", in_ready_v[1], 1);
    check("fl_idle_busy", busy_v[1], 0);
    check("fl_idle_ov", out_valid_v[1], 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fl_no_valid", out_valid_v[1], 0);
    end
    // Flush beats in_valid in IDLE.
    in_valid_v[1] = 1'b1; flush_v[1] = 1'b1;
    in1_v[1] = 16'h01; in2_v[1] = 16'h02; in3_v[1] = 16'h03;
    tick();
    in_valid_v[1] = 1'b0; flush_v[1] = 1'b0;
    check("fl_no_capture", busy_v[1], 0);
    lat_op(16'h12, 16'h34, 16'h56, 1'b1, 18'h09D, "fl_next");

    // Flush in DONE with a pending result, overriding out_ready.
    send(1, 16'h80, 16'h80, 16'h80, 1'b0, "fld");
    wait_valid(1, "fld");
    flush_v[1] = 1'b1; out_ready_v[1] = 1'b1;
    tick();
    flush_v[1] = 1'b0; out_ready_v[1] = 1'b0;
    check("fld_ov", out_valid_v[1], 0);
    check("fld_ready", in_ready_v[1], 1);

    // Asynchronous reset mid-RUN.
    send(1, 16'hFF, 16'hFF, 16'hFF, 1'b1, "ar");
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_in_ready", in_ready_v[1], 1);
    check("ar_out_valid", out_valid_v[1], 0);
    check("ar_busy", busy_v[1], 0);
    check("ar_sum", sum_v[1], 0);
    #10;
    rst_n = 1'b1;
    tick();
    lat_op(16'h0F, 16'hF0, 16'h3C, 1'b1, 18'h13C, "post_rst");

    run_random(0, 1000);
    run_random(2, 1000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
